// File: rtl/config_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package config_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOW,
        HIGH,
        FINISH
    } state_t;

    localparam logic MODE_LOAD   = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

    // Number of input words needed to cover the whole chain.
    function automatic int unsigned num_words(input int unsigned config_width,
                                              input int unsigned word_width);
        return (config_width + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/config_phase_ctr.sv
// Counts CLK_DIV cycles of a config_clk half-period; tick marks the last cycle.
module config_phase_ctr
    import config_loader_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Wraps on tick so back-to-back phases restart from zero without a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/config_loader.sv
// Streams a parallel-word bitstream LSB-first into the fabric configuration
// chain, optionally comparing the chain output against the same stream.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CONFIG_WIDTH = 2048,
    parameter int WORD_WIDTH   = 32,
    parameter int CLK_DIV      = 2,
    parameter int MISMATCH_W   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                mode,
    input  logic [WORD_WIDTH-1:0]               word_data,
    input  logic                                word_valid,
    output logic                                word_ready,
    output logic                                config_in,
    output logic                                config_clk,
    output logic                                config_en,
    input  logic                                config_out,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [$clog2(CONFIG_WIDTH+1)-1:0]   bit_count,
    output logic [MISMATCH_W-1:0]               mismatch_count
);

    localparam int BC_W = $clog2(CONFIG_WIDTH + 1);
    localparam int WL_W = $clog2(WORD_WIDTH + 1);

    state_t                  state, state_n;
    logic                    word_ready_n;
    logic                    config_in_n;
    logic                    config_clk_n;
    logic                    config_en_n;
    logic                    busy_n;
    logic                    done_n;
    logic                    error_n;
    logic [BC_W-1:0]         bit_count_n;
    logic [MISMATCH_W-1:0]   mismatch_n;
    logic [WL_W-1:0]         word_left, word_left_n;

    // Bit 0 of a fetched word goes straight to config_in, so only the rest is buffered.
    logic [WORD_WIDTH-2:0]   shreg;
    logic                    mode_q;
    logic                    run;
    logic                    tick;

    assign run = (state == LOW) || (state == HIGH) || (state == FINISH);

    config_phase_ctr #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    always_comb begin
        state_n      = state;
        word_ready_n = word_ready;
        config_in_n  = config_in;
        config_clk_n = config_clk;
        config_en_n  = config_en;
        busy_n       = busy;
        done_n       = 1'b0;
        error_n      = error;
        bit_count_n  = bit_count;
        mismatch_n   = mismatch_count;
        word_left_n  = word_left;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = FETCH;
                    word_ready_n = 1'b1;
                    config_en_n  = 1'b1;
                    busy_n       = 1'b1;
                    error_n      = 1'b0;
                    bit_count_n  = '0;
                    mismatch_n   = '0;
                end
            end

            FETCH: begin
                // Underrun simply waits here with config_clk low and config_en high.
                if (word_valid) begin
                    state_n      = LOW;
                    word_ready_n = 1'b0;
                    config_in_n  = word_data[0];
                    word_left_n  = WL_W'(WORD_WIDTH);
                end
            end

            LOW: begin
                if (tick) begin
                    if (mode_q == MODE_VERIFY && config_out != config_in) begin
                        error_n = 1'b1;
                        if (mismatch_count != '1) begin
                            mismatch_n = mismatch_count + 1'b1;
                        end
                    end
                    state_n      = HIGH;
                    config_clk_n = 1'b1;
                    bit_count_n  = bit_count + 1'b1;
                end
            end

            HIGH: begin
                if (tick) begin
                    config_clk_n = 1'b0;
                    word_left_n  = word_left - 1'b1;
                    if (bit_count == BC_W'(CONFIG_WIDTH)) begin
                        state_n = FINISH;
                    end else if (word_left == WL_W'(1)) begin
                        state_n      = FETCH;
                        word_ready_n = 1'b1;
                    end else begin
                        state_n     = LOW;
                        config_in_n = shreg[0];
                    end
                end
            end

            FINISH: begin
                if (tick) begin
                    state_n     = IDLE;
                    config_en_n = 1'b0;
                    busy_n      = 1'b0;
                    done_n      = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            word_ready     <= 1'b0;
            config_in      <= 1'b0;
            config_clk     <= 1'b0;
            config_en      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            bit_count      <= '0;
            mismatch_count <= '0;
            word_left      <= '0;
        end else begin
            state          <= state_n;
            word_ready     <= word_ready_n;
            config_in      <= config_in_n;
            config_clk     <= config_clk_n;
            config_en      <= config_en_n;
            busy           <= busy_n;
            done           <= done_n;
            error          <= error_n;
            bit_count      <= bit_count_n;
            mismatch_count <= mismatch_n;
            word_left      <= word_left_n;
        end
    end

    // Datapath registers carry no reset; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            mode_q <= mode;
        end
        if (state == FETCH && word_valid) begin
            shreg <= word_data[WORD_WIDTH-1:1];
        end else if (state == HIGH && tick) begin
            shreg <= shreg >> 1;
        end
    end

endmodule
